alu_cmd_issue: RTL and testbench
================================

Name: alu_cmd_issue

Overview:
- Upstream command front-end for the 4-bit arithmetic unit `ALU`.
- Accepts tagged operations through a valid/ready command port and buffers them in a small command FIFO.
- Drives the ALU's operand and select inputs, one operation per CLK.
- Tracks the ALU's fixed two-register latency with a valid/tag shadow pipe, captures `d`/`cout` into a result FIFO, and returns tagged results through a valid/ready port.
- The ALU has no enable and no stall, so back-pressure is handled by credit-based issue.

Parameters:
- CDEPTH, 4: command FIFO depth (power of 2, ≥2).
- RDEPTH, 4: result FIFO depth (≥ ALU_LAT+2).
- ALU_LAT, 2: ALU register stages (input register + output register).
- TAGW, 4: command/result tag width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command FIFO not full.
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- cmd_op  in  3  {s0,s1,cin}.
- cmd_tag  in  TAGW  user tag.
- alu_a  out  4  to ALU a.
- alu_b  out  4  to ALU b.
- alu_s0  out  1  to ALU s0.
- alu_s1  out  1  to ALU s1.
- alu_cin  out  1  to ALU cin.
- alu_d  in  4  from ALU d.
- alu_cout  in  1  from ALU cout.
- res_valid  out  1  result FIFO not empty.
- res_ready  in  1  consumer accepts.
- res_d  out  4  result value.
- res_cout  out  1  result carry.
- res_tag  out  TAGW  tag of result.
- busy  out  1  any command queued, in flight, or result pending.

Behaviour:
- Reset (async, RST=1):
  - Both FIFOs empty; shadow pipe cleared.
  - Outputs: cmd_ready=1, res_valid=0, busy=0; alu_a, alu_b, alu_s0, alu_s1, alu_cin = 0; res_d, res_cout, res_tag = 0.
- Command accept:
  - Push on posedge when cmd_valid && cmd_ready.
  - cmd_ready = !cmd_full, derived from registered count only; no push-through when full, even if an issue happens the same cycle.
- Issue condition, evaluated each cycle: cmd FIFO not empty AND (rcount + inflight − (res_valid && res_ready)) < RDEPTH.
  - rcount = result FIFO occupancy.
  - inflight = set bits in the shadow pipe.
- Issue effects at posedge E:
  - alu_* registers load the head fields (alu_s0/alu_s1/alu_cin = cmd_op[2]/[1]/[0]).
  - Head is popped.
  - Shadow-pipe stage 0 loads {1, tag}.
  - No issue: alu_* hold their previous values and shadow stage 0 loads valid=0.
- Shadow pipe:
  - ALU_LAT+1 stages; shifts every cycle.
  - The stage leaving at posedge E+ALU_LAT+1 writes {alu_d, alu_cout, tag} into the result FIFO, if its valid bit is set.
  - Space is guaranteed by the credit rule; an overflow is a design error (assert in simulation).
- Latency:
  - cmd accept at edge T → earliest issue T+1 → ALU captures T+2 → ALU output T+3 → result FIFO write T+4 → res_valid=1 after T+4.
  - Throughput: 1 op/cycle when res_ready is held at 1.
- Ordering: results return strictly in command order; tags travel unmodified.
- Result pop: on posedge when res_valid && res_ready. res_* always show the FIFO head (registered).
- Simultaneous events:
  - Push, issue, capture and pop may all occur on the same edge; counts update by the net change.
  - Pop credit applies in the same cycle it occurs.
- Stall: with res_ready=0, at most RDEPTH ops are outstanding (issued but not popped). Issue stops; cmd_ready falls once CDEPTH commands are queued.
- ALU op semantics (expected d, 4-bit wrap; cout = carry out of bit 3):
  - 000 A+B; 001 A+B+1; 010 A+~B; 011 A−B.
  - 100 A; 101 A+1; 110 A−1; 111 A.
- Reset mid-operation:
  - Everything clears immediately.
  - Values still emerging from the ALU registers after reset are discarded, because their shadow valid bits are 0.
  - No stale result ever appears on res_*.
- busy = cmd count ≠ 0 OR inflight ≠ 0 OR rcount ≠ 0.

Test Plan:
- Single op: a=1010, b=0101, op=000, tag=3, pulsed at edge T, res_ready=1 → res_valid at T+4, res_d=1111, res_cout=0, res_tag=3.
- Back-to-back ops 011, 110, 101 with a=1010/0000/1111, b=0101, tags 1,2,3 → consecutive cycles give (0101,1), (1111,0), (0000,1) in tag order 1,2,3.
- Back-pressure: res_ready=0, push 10 commands → exactly RDEPTH results held, CDEPTH queued, cmd_ready=0. Release res_ready → all 10 drain in order with no loss or duplication.
- Simultaneous pop and issue at full credit (res_ready toggling 1/0/1) → no overflow assertion; result sequence matches the reference model.
- Reset mid-flight: assert RST asynchronously with 3 ops in flight → all outputs at reset values immediately; after release, res_valid stays 0 for ≥4 cycles until new commands are sent.
- Random 1000 ops with random cmd_valid/res_ready → every result equals the op table above, tags in order, busy=0 at end.

Source files
------------

// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: command front-end for the 4-bit arithmetic unit ALU.
//
// Tagged commands are accepted over a valid/ready port and queued in a command FIFO.
// One command per cycle is issued to the ALU's operand/select registers. The ALU has
// a fixed ALU_LAT-register latency and cannot stall, so a valid/tag shadow pipe follows
// each issued op and writes {d, cout, tag} into a result FIFO when the ALU output is
// ready. An op is issued only if its result is guaranteed a slot. That slot is counted
// against result occupancy plus ops in flight, less a pop on the same edge.
//
// Ports:
//   CLK, RST                 clock (posedge), asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_ready = command FIFO not full
//   cmd_a, cmd_b             4-bit operands
//   cmd_op                   {s0, s1, cin}
//   cmd_tag                  user tag, returned with the result
//   alu_a, alu_b             registered operands to the ALU
//   alu_s0, alu_s1, alu_cin  registered select/carry to the ALU
//   alu_d, alu_cout          ALU result, ALU_LAT cycles after alu_* load
//   res_valid/res_ready      result handshake; res_valid = result FIFO not empty
//   res_d, res_cout, res_tag result FIFO head (zero while empty)
//   busy                     anything queued, in flight, or awaiting pop
module alu_cmd_issue #(
    parameter int CDEPTH  = 4,
    parameter int RDEPTH  = 4,
    parameter int ALU_LAT = 2,
    parameter int TAGW    = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [3:0]      cmd_a,
    input  logic [3:0]      cmd_b,
    input  logic [2:0]      cmd_op,
    input  logic [TAGW-1:0] cmd_tag,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    output logic            alu_s0,
    output logic            alu_s1,
    output logic            alu_cin,
    input  logic [3:0]      alu_d,
    input  logic            alu_cout,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [3:0]      res_d,
    output logic            res_cout,
    output logic [TAGW-1:0] res_tag,
    output logic            busy
);

    localparam int CAW  = (CDEPTH > 1) ? $clog2(CDEPTH) : 1;
    localparam int CCW  = $clog2(CDEPTH + 1);
    localparam int RAW  = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
    localparam int RCW  = $clog2(RDEPTH + 1);
    localparam int CMDW = 4 + 4 + 3 + TAGW;
    localparam int RESW = 4 + 1 + TAGW;

    localparam logic [CAW-1:0] CLAST = CAW'(CDEPTH - 1);
    localparam logic [CCW-1:0] CFULL = CCW'(CDEPTH);
    localparam logic [RAW-1:0] RLAST = RAW'(RDEPTH - 1);
    localparam logic [RCW-1:0] RFULL = RCW'(RDEPTH);

    function automatic logic [CAW-1:0] cmd_ptr_next(input logic [CAW-1:0] p);
        return (p == CLAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [RAW-1:0] res_ptr_next(input logic [RAW-1:0] p);
        return (p == RLAST) ? '0 : p + 1'b1;
    endfunction

    // Command FIFO
    logic [CMDW-1:0] cmem [CDEPTH];
    logic [CAW-1:0]  cwptr, crptr;
    logic [CCW-1:0]  ccount;
    logic            push, issue, res_pop, res_wr;

    logic [3:0]      head_a, head_b;
    logic [2:0]      head_op;
    logic [TAGW-1:0] head_tag;

    assign cmd_ready = (ccount != CFULL);
    assign push      = cmd_valid && cmd_ready;
    assign {head_a, head_b, head_op, head_tag} = cmem[crptr];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cwptr  <= '0;
            crptr  <= '0;
            ccount <= '0;
        end else begin
            if (push)  cwptr <= cmd_ptr_next(cwptr);
            if (issue) crptr <= cmd_ptr_next(crptr);
            case ({push, issue})
                2'b10:   ccount <= ccount + 1'b1;
                2'b01:   ccount <= ccount - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) cmem[cwptr] <= {cmd_a, cmd_b, cmd_op, cmd_tag};
    end

    // Issue credit: a pop on this edge frees a slot for the op issued on the same edge.
    logic [RCW-1:0]   rcount;
    logic [ALU_LAT:0] shadow_vld;
    logic [31:0]      credit_used;

    always_comb begin
        credit_used = 32'(rcount) + 32'($countones(shadow_vld)) - 32'(res_pop);
        issue       = (ccount != '0) && (credit_used < 32'(RDEPTH));
    end

    // Stage p0: ALU operand/select registers and head of the shadow pipe
    logic [TAGW-1:0] shadow_tag [ALU_LAT+1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_s0     <= 1'b0;
            alu_s1     <= 1'b0;
            alu_cin    <= 1'b0;
            shadow_vld <= '0;
        end else begin
            shadow_vld <= {shadow_vld[ALU_LAT-1:0], issue};
            if (issue) begin
                alu_a   <= head_a;
                alu_b   <= head_b;
                alu_s0  <= head_op[2];
                alu_s1  <= head_op[1];
                alu_cin <= head_op[0];
            end
        end
    end

    // Stages p1..pALU_LAT: tags shadow the ALU registers; valid bits gate capture
    always_ff @(posedge CLK) begin
        shadow_tag[0] <= head_tag;
        for (int i = 1; i <= ALU_LAT; i++) shadow_tag[i] <= shadow_tag[i-1];
    end

    // Capture into result FIFO as the last shadow stage leaves
    logic [RESW-1:0] rmem [RDEPTH];
    logic [RAW-1:0]  rwptr, rrptr;

    assign res_wr    = shadow_vld[ALU_LAT];
    assign res_valid = (rcount != '0);
    assign res_pop   = res_valid && res_ready;
    assign busy      = (ccount != '0) || (|shadow_vld) || res_valid;
    // Gated so an empty FIFO (including straight after reset) shows zeros, never stale data.
    assign {res_d, res_cout, res_tag} = res_valid ? rmem[rrptr] : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rwptr  <= '0;
            rrptr  <= '0;
            rcount <= '0;
        end else begin
            if (res_wr)  rwptr <= res_ptr_next(rwptr);
            if (res_pop) rrptr <= res_ptr_next(rrptr);
            case ({res_wr, res_pop})
                2'b10:   rcount <= rcount + 1'b1;
                2'b01:   rcount <= rcount - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (res_wr) rmem[rwptr] <= {alu_d, alu_cout, shadow_tag[ALU_LAT]};
    end

    // The credit rule makes this unreachable; firing means the issue logic is broken.
    res_fifo_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(res_wr && !res_pop && (rcount == RFULL)));

endmodule

// File: tb/tb_alu_cmd_issue.sv
module tb_alu_cmd_issue;
    localparam int CDEPTH  = 4;
    localparam int RDEPTH  = 4;
    localparam int ALU_LAT = 2;
    localparam int TAGW    = 4;

    logic            CLK = 1'b0;
    logic            RST;
    logic            cmd_valid, cmd_ready;
    logic [3:0]      cmd_a, cmd_b;
    logic [2:0]      cmd_op;
    logic [TAGW-1:0] cmd_tag;
    logic [3:0]      alu_a, alu_b;
    logic            alu_s0, alu_s1, alu_cin;
    logic [3:0]      alu_d;
    logic            alu_cout;
    logic            res_valid, res_ready;
    logic [3:0]      res_d;
    logic            res_cout;
    logic [TAGW-1:0] res_tag;
    logic            busy;

    always #5 CLK = ~CLK;

    alu_cmd_issue #(.CDEPTH(CDEPTH), .RDEPTH(RDEPTH), .ALU_LAT(ALU_LAT), .TAGW(TAGW)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_cin(alu_cin),
        .alu_d(alu_d), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_d(res_d), .res_cout(res_cout), .res_tag(res_tag),
        .busy(busy)
    );

    // ALU: input register then output register, no reset, no stall.
    // Gate-level view: adder of A with Y = {B, ~B, 0000, 1111} plus cin.
    logic [3:0] ia, ib;
    logic       is0, is1, icin;
    logic [3:0] y;
    assign y = is0 ? {4{is1}} : (is1 ? ~ib : ib);
    always_ff @(posedge CLK) begin
        ia   <= alu_a;
        ib   <= alu_b;
        is0  <= alu_s0;
        is1  <= alu_s1;
        icin <= alu_cin;
        {alu_cout, alu_d} <= {1'b0, ia} + {1'b0, y} + {4'd0, icin};
    end

    // Reference: the op table written as plain integer arithmetic.
    function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
        int x, z, s;
        x = int'(a);
        z = int'(b);
        case (op)
            3'b000:  s = x + z;
            3'b001:  s = x + z + 1;
            3'b010:  s = x + (15 - z);
            3'b011:  s = x + 16 - z;
            3'b100:  s = x;
            3'b101:  s = x + 1;
            3'b110:  s = x + 15;
            default: s = x + 16;
        endcase
        return 5'(s);
    endfunction

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic            cout;
        logic [3:0]      d;
    } res_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] tag;
        logic [3:0] d;
        logic       cout;
    } vec_t;

    res_t expq[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_push = 0;
    int   n_pop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // One clock: sample handshakes at negedge, return 1ns after the posedge.
    task automatic tick();
        res_t        e;
        logic [4:0]  r;
        @(negedge CLK);
        if (cmd_valid && cmd_ready) begin
            r = ref_alu(cmd_a, cmd_b, cmd_op);
            e.tag  = cmd_tag;
            e.cout = r[4];
            e.d    = r[3:0];
            expq.push_back(e);
            n_push++;
        end
        if (res_valid && res_ready) begin
            n_pop++;
            check("res_expected_present", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                check("res_value_order", {23'd0, res_tag, res_cout, res_d}, {23'd0, e});
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                         input logic [3:0] tag);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_tag   = tag;
    endtask

    task automatic drain(input string name, input int budget);
        int c;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        c = 0;
        while ((busy || expq.size() != 0) && c < budget) begin
            tick();
            c++;
        end
        check({name, "_drain_busy"}, 32'(busy), 32'd0);
        check({name, "_drain_queue"}, 32'(expq.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({name, "_res_valid"}, 32'(res_valid), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_alu_ab"}, {24'd0, alu_a, alu_b}, 32'd0);
        check({name, "_alu_sel"}, {29'd0, alu_s0, alu_s1, alu_cin}, 32'd0);
        check({name, "_res_out"}, {23'd0, res_tag, res_cout, res_d}, 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        int base, idx, c, pops0;

        vecs[0] = '{4'hA, 4'h5, 3'b000, 4'd3,  4'hF, 1'b0};
        vecs[1] = '{4'hA, 4'h5, 3'b001, 4'd4,  4'h0, 1'b1};
        vecs[2] = '{4'h3, 4'h5, 3'b010, 4'd5,  4'hD, 1'b0};
        vecs[3] = '{4'hA, 4'h5, 3'b011, 4'd6,  4'h5, 1'b1};
        vecs[4] = '{4'h7, 4'h9, 3'b011, 4'd7,  4'hE, 1'b0};
        vecs[5] = '{4'h9, 4'h2, 3'b100, 4'd8,  4'h9, 1'b0};
        vecs[6] = '{4'hF, 4'h2, 3'b101, 4'd9,  4'h0, 1'b1};
        vecs[7] = '{4'h0, 4'h2, 3'b110, 4'd10, 4'hF, 1'b0};
        vecs[8] = '{4'h6, 4'h2, 3'b111, 4'd11, 4'h6, 1'b1};
        vecs[9] = '{4'hF, 4'hF, 3'b000, 4'd12, 4'hE, 1'b1};

        RST       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        cmd_tag   = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RST = 1'b0;
        tick();
        check("idle_res_valid", 32'(res_valid), 32'd0);

        // Single ops from the table, with exact latency
        res_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag);
            tick();
            cmd_valid = 1'b0;
            tick();
            tick();
            tick();
            check($sformatf("vec%0d_not_early", i), 32'(res_valid), 32'd0);
            tick();
            check($sformatf("vec%0d_valid", i), 32'(res_valid), 32'd1);
            check($sformatf("vec%0d_result", i), {23'd0, res_tag, res_cout, res_d},
                  {23'd0, vecs[i].tag, vecs[i].cout, vecs[i].d});
            tick();
        end

        // Back-to-back ops on consecutive cycles
        drive(4'hA, 4'h5, 3'b011, 4'd1); tick();
        drive(4'h0, 4'h5, 3'b110, 4'd2); tick();
        drive(4'hF, 4'h5, 3'b101, 4'd3); tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("b2b_r1", {22'd0, res_valid, res_tag, res_cout, res_d}, {22'd0, 1'b1, 4'd1, 1'b1, 4'h5});
        tick();
        check("b2b_r2", {22'd0, res_valid, res_tag, res_cout, res_d}, {22'd0, 1'b1, 4'd2, 1'b0, 4'hF});
        tick();
        check("b2b_r3", {22'd0, res_valid, res_tag, res_cout, res_d}, {22'd0, 1'b1, 4'd3, 1'b1, 4'h0});
        drain("b2b", 20);

        // Back-pressure: 10 commands against a stalled consumer
        res_ready = 1'b0;
        base  = n_push;
        pops0 = n_pop;
        idx   = 0;
        for (int k = 0; k < 20; k++) begin
            drive(4'(idx), ~4'(idx), 3'(idx), 4'(idx));
            cmd_valid = (idx < 10);
            tick();
            idx = n_push - base;
        end
        check("bp_accepted", 32'(idx), 32'(RDEPTH + CDEPTH));
        check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        check("bp_res_head", {30'd0, res_valid, busy}, 32'd3);
        check("bp_head_tag", 32'(res_tag), 32'd0);
        res_ready = 1'b1;
        c = 0;
        while ((idx < 10 || busy) && c < 100) begin
            drive(4'(idx), ~4'(idx), 3'(idx), 4'(idx));
            cmd_valid = (idx < 10);
            tick();
            idx = n_push - base;
            c++;
        end
        check("bp_total_accepted", 32'(idx), 32'd10);
        check("bp_total_popped", 32'(n_pop - pops0), 32'd10);
        drain("bp", 20);

        // Full credit with res_ready toggling 1/0/1
        base  = n_push;
        pops0 = n_pop;
        c     = 0;
        while (n_push - base < 24 && c < 200) begin
            idx = n_push - base;
            drive(4'(idx * 3), 4'(idx * 5), 3'(idx), 4'(idx));
            res_ready = (c % 3 != 1);
            tick();
            c++;
        end
        drain("toggle", 60);
        check("toggle_popped", 32'(n_pop - pops0), 32'd24);

        // Reset with three ops in flight
        drive(4'h9, 4'h3, 3'b000, 4'd5); tick();
        drive(4'hC, 4'h3, 3'b001, 4'd6); tick();
        drive(4'h7, 4'h3, 3'b010, 4'd7); tick();
        cmd_valid = 1'b0;
        tick();
        #1;
        RST = 1'b1;
        #1;
        check_reset_outputs("midreset");
        expq.delete();
        #3;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("post_reset_quiet%0d", k), 32'(res_valid), 32'd0);
        end

        // Random traffic against the reference queue
        base  = n_push;
        pops0 = n_pop;
        c     = 0;
        while (n_push - base < 1000 && c < 20000) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_a     = 4'($urandom);
            cmd_b     = 4'($urandom);
            cmd_op    = 3'($urandom);
            cmd_tag   = 4'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            tick();
            c++;
        end
        check("rand_accepted", 32'(n_push - base), 32'd1000);
        drain("rand", 100);
        check("rand_popped", 32'(n_pop - pops0), 32'd1000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1);
    end

endmodule
